cmp_arbiter: RTL and testbench

Shares the single 32-bit comparator between two requesters: requester 0 is the branch-resolution path, requester 1 is the set-on-compare path. The block accepts one compare request per transaction through a valid/ready handshake and arbitrates between the requesters round-robin. It latches the operands and the operation code, runs the comparator from registered inputs, and returns a registered one-bit result to the requester that was granted. It sits in the execute stage between the decode/issue logic and the comparator instance it owns.

---
 rtl/cmp_arbiter.sv | 266 ++++++++++++++++++++++++++
 tb/tb_cmp_arbiter.sv | 265 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/cmp_arbiter.sv
// ============================================================================
// cmp_arbiter
// ----------------------------------------------------------------------------
// Shares one WIDTH-bit comparator between two requesters in the execute stage:
//   requester 0 - branch-resolution path
//   requester 1 - set-on-compare path
// One compare is accepted per transaction through a valid/ready handshake.
// The operands, operation code and grant ID are latched. The comparator
// evaluates the latched values for one cycle. A registered one-bit result is
// then returned to the requester that was granted.
//
// Transaction timing, with the handshake in cycle T:
//   T    : IDLE, reqN_ready high, operands latched
//   T+1  : EXEC, comparator evaluates the latched operands, busy high
//   T+2  : RESP, respN_valid pulses with resp_val/resp_err, busy high
//   T+3  : IDLE, the next handshake can be taken
//
// Configuration macro:
//   CMP_ARB_FIXED_PRIO_EN - when defined, requester 0 always wins a tie.
//                           When undefined (the default), a tie goes to the
//                           requester that was not granted last (round-robin).
//
// Ports:
//   clk                        clock, rising edge
//   rst                        synchronous active-high reset
//   req0_valid / req1_valid    compare request pending
//   req0_ready / req1_ready    handshake accepted this cycle (combinational)
//   reqN_a, reqN_b             operands, WIDTH bits
//   reqN_oper                  operation code: 000 ==, 001 !=, 010 <, 011 <=,
//                              100 >, 101 >=; 110 and 111 are illegal
//   resp0_valid / resp1_valid  one-cycle pulse, the result belongs to requester N
//   resp_val                   compare result, shared by both responses
//   resp_err                   the latched operation code was illegal
//   busy                       a transaction is in EXEC or RESP
// ============================================================================

// ----------------------------------------------------------------------------
// cmp_unit: the comparator instance that the arbiter owns.
// Less-than is the sign bit of the WIDTH-bit difference a-b, and no overflow
// correction is applied. For example, 0x80000000 < 1 gives 0, and
// 0x7fffffff < 0x80000000 gives 1.
// ----------------------------------------------------------------------------
module cmp_unit #(
    parameter int WIDTH = 32
) (
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic [2:0]       oper,
    output logic             val,
    output logic             err
);
    localparam logic [2:0] OP_EQ = 3'b000;
    localparam logic [2:0] OP_NE = 3'b001;
    localparam logic [2:0] OP_LT = 3'b010;
    localparam logic [2:0] OP_LE = 3'b011;
    localparam logic [2:0] OP_GT = 3'b100;
    localparam logic [2:0] OP_GE = 3'b101;

    logic [WIDTH-1:0] diff;
    logic             eq;
    logic             lt;

    assign diff = a - b;
    assign eq   = (a == b);
    assign lt   = diff[WIDTH-1];

    // NOTE: every output of a combinational block gets a default first, so
    // that a path which misses an assignment cannot infer a latch.
    always_comb begin
        val = 1'b0;
        err = 1'b0;
        case (oper)
            OP_EQ:   val = eq;
            OP_NE:   val = ~eq;
            OP_LT:   val = lt;
            OP_LE:   val = lt | eq;
            OP_GT:   val = ~lt & ~eq;
            OP_GE:   val = ~lt;
            default: err = 1'b1;   // 110 / 111: the result is forced to 0
        endcase
    end
endmodule

// ----------------------------------------------------------------------------
// cmp_arbiter: top level
// ----------------------------------------------------------------------------
module cmp_arbiter #(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             rst,

    input  logic             req0_valid,
    output logic             req0_ready,
    input  logic [WIDTH-1:0] req0_a,
    input  logic [WIDTH-1:0] req0_b,
    input  logic [2:0]       req0_oper,

    input  logic             req1_valid,
    output logic             req1_ready,
    input  logic [WIDTH-1:0] req1_a,
    input  logic [WIDTH-1:0] req1_b,
    input  logic [2:0]       req1_oper,

    output logic             resp0_valid,
    output logic             resp1_valid,
    output logic             resp_val,
    output logic             resp_err,
    output logic             busy
);
    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_EXEC = 2'd1,
        S_RESP = 2'd2
    } state_e;

    // ------------------------------------------------------------------
    // State and registered outputs
    // ------------------------------------------------------------------
    state_e           state_q,       state_d;
    logic             last_grant_q,  last_grant_d;
    logic             id_q,          id_d;
    logic [WIDTH-1:0] a_q,           a_d;
    logic [WIDTH-1:0] b_q,           b_d;
    logic [2:0]       oper_q,        oper_d;
    logic             resp0_valid_q, resp0_valid_d;
    logic             resp1_valid_q, resp1_valid_d;
    logic             resp_val_q,    resp_val_d;
    logic             resp_err_q,    resp_err_d;
    logic             busy_q,        busy_d;

    // ------------------------------------------------------------------
    // Arbitration (combinational, from valid and the last-grant pointer)
    // ------------------------------------------------------------------
    logic tie_winner;
    logic grant_id;
    logic handshake;

    always_comb begin
`ifdef CMP_ARB_FIXED_PRIO_EN
        tie_winner = 1'b0;
`else
        // Round-robin: the requester that was not served last wins a tie.
        tie_winner = ~last_grant_q;
`endif
        if (req0_valid && req1_valid) begin
            grant_id = tie_winner;
        end else begin
            grant_id = req1_valid;   // the only valid requester; 0 if none
        end
    end

    // Ready depends on valid, so an idle requester never sees ready high.
    assign req0_ready = (state_q == S_IDLE) && req0_valid && (grant_id == 1'b0);
    assign req1_ready = (state_q == S_IDLE) && req1_valid && (grant_id == 1'b1);
    assign handshake  = req0_ready | req1_ready;

    // ------------------------------------------------------------------
    // Comparator, driven only from the latched registers
    // ------------------------------------------------------------------
    logic cmp_val;
    logic cmp_err;

    cmp_unit #(
        .WIDTH (WIDTH)
    ) u_cmp (
        .a    (a_q),
        .b    (b_q),
        .oper (oper_q),
        .val  (cmp_val),
        .err  (cmp_err)
    );

    // ------------------------------------------------------------------
    // Next-state logic
    // ------------------------------------------------------------------
    always_comb begin
        state_d       = state_q;
        last_grant_d  = last_grant_q;
        id_d          = id_q;
        a_d           = a_q;
        b_d           = b_q;
        oper_d        = oper_q;
        resp0_valid_d = 1'b0;
        resp1_valid_d = 1'b0;
        resp_val_d    = resp_val_q;   // held outside RESP
        resp_err_d    = resp_err_q;
        busy_d        = busy_q;

        case (state_q)
            S_IDLE: begin
                busy_d = 1'b0;
                if (handshake) begin
                    id_d         = grant_id;
                    last_grant_d = grant_id;
                    a_d          = grant_id ? req1_a    : req0_a;
                    b_d          = grant_id ? req1_b    : req0_b;
                    oper_d       = grant_id ? req1_oper : req0_oper;
                    busy_d       = 1'b1;
                    state_d      = S_EXEC;
                end
            end
            S_EXEC: begin
                // The result is registered here so that it appears together
                // with the response pulse in RESP.
                resp_val_d    = cmp_val;
                resp_err_d    = cmp_err;
                resp0_valid_d = (id_q == 1'b0);
                resp1_valid_d = (id_q == 1'b1);
                busy_d        = 1'b1;
                state_d       = S_RESP;
            end
            S_RESP: begin
                // No handshake is taken in this cycle; ready is low outside IDLE.
                busy_d  = 1'b0;
                state_d = S_IDLE;
            end
            default: begin
                busy_d  = 1'b0;
                state_d = S_IDLE;
            end
        endcase
    end

    // ------------------------------------------------------------------
    // Registers
    // ------------------------------------------------------------------
    // NOTE: sequential state uses non-blocking assignments only, so that
    // every flop samples the values from before the edge.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q       <= S_IDLE;
            last_grant_q  <= 1'b1;      // requester 0 wins the first tie
            id_q          <= 1'b0;
            // NOTE: the latched operands are plain flops, not a memory, so
            // they are cleared with the rest of the state.
            a_q           <= '0;
            b_q           <= '0;
            oper_q        <= 3'b000;
            resp0_valid_q <= 1'b0;
            resp1_valid_q <= 1'b0;
            resp_val_q    <= 1'b0;
            resp_err_q    <= 1'b0;
            busy_q        <= 1'b0;
        end else begin
            state_q       <= state_d;
            last_grant_q  <= last_grant_d;
            id_q          <= id_d;
            a_q           <= a_d;
            b_q           <= b_d;
            oper_q        <= oper_d;
            resp0_valid_q <= resp0_valid_d;
            resp1_valid_q <= resp1_valid_d;
            resp_val_q    <= resp_val_d;
            resp_err_q    <= resp_err_d;
            busy_q        <= busy_d;
        end
    end

    assign resp0_valid = resp0_valid_q;
    assign resp1_valid = resp1_valid_q;
    assign resp_val    = resp_val_q;
    assign resp_err    = resp_err_q;
    assign busy        = busy_q;

endmodule

// File: tb/tb_cmp_arbiter.sv
// ============================================================================
// tb_cmp_arbiter: directed, self-checking bench for cmp_arbiter.
// Inputs are driven on the falling edge. Outputs are checked on the falling
// edge, or 1 time unit after it for the combinational ready signals.
// The fixed-priority build uses the same bench, with +define+CMP_ARB_FIXED_PRIO_EN.
// ============================================================================
module tb_cmp_arbiter;
    localparam int WIDTH = 32;

    logic             clk = 1'b0;
    logic             rst;
    logic             req0_valid, req0_ready;
    logic [WIDTH-1:0] req0_a, req0_b;
    logic [2:0]       req0_oper;
    logic             req1_valid, req1_ready;
    logic [WIDTH-1:0] req1_a, req1_b;
    logic [2:0]       req1_oper;
    logic             resp0_valid, resp1_valid, resp_val, resp_err, busy;

    int errors = 0;
    int checks = 0;

    always #5 clk = ~clk;

    cmp_arbiter #(.WIDTH(WIDTH)) dut (
        .clk         (clk),
        .rst         (rst),
        .req0_valid  (req0_valid),
        .req0_ready  (req0_ready),
        .req0_a      (req0_a),
        .req0_b      (req0_b),
        .req0_oper   (req0_oper),
        .req1_valid  (req1_valid),
        .req1_ready  (req1_ready),
        .req1_a      (req1_a),
        .req1_b      (req1_b),
        .req1_oper   (req1_oper),
        .resp0_valid (resp0_valid),
        .resp1_valid (resp1_valid),
        .resp_val    (resp_val),
        .resp_err    (resp_err),
        .busy        (busy)
    );

    // Stimulus helper for one requester's inputs.
    task automatic drive(input int id, input logic [WIDTH-1:0] a, input logic [WIDTH-1:0] b,
                         input logic [2:0] op, input logic vld);
        if (id == 0) begin
            req0_valid = vld; req0_a = a; req0_b = b; req0_oper = op;
        end else begin
            req1_valid = vld; req1_a = a; req1_b = b; req1_oper = op;
        end
    endtask

    // One complete transaction from a single requester: T, T+1, T+2, T+3.
    task automatic single_txn(input string name, input int id,
                              input logic [WIDTH-1:0] a, input logic [WIDTH-1:0] b,
                              input logic [2:0] op, input logic exp_val, input logic exp_err);
        logic exp_r0, exp_r1;
        exp_r0 = (id == 0);
        exp_r1 = (id == 1);
        @(negedge clk);
        drive(id, a, b, op, 1'b1);
        #1;
        checks++;
        if ({req0_ready, req1_ready} !== {exp_r0, exp_r1}) begin
            errors++;
            $display("FAIL %s ready@T: got r0=%b r1=%b expected r0=%b r1=%b",
                     name, req0_ready, req1_ready, exp_r0, exp_r1);
        end
        @(negedge clk);                  // T+1 (EXEC)
        drive(id, a, b, op, 1'b0);
        checks++;
        if ({busy, resp0_valid, resp1_valid} !== 3'b100) begin
            errors++;
            $display("FAIL %s exec: got busy/r0v/r1v=%b expected 100",
                     name, {busy, resp0_valid, resp1_valid});
        end
        @(negedge clk);                  // T+2 (RESP)
        checks++;
        if ({busy, resp0_valid, resp1_valid, resp_val, resp_err} !==
            {1'b1, exp_r0, exp_r1, exp_val, exp_err}) begin
            errors++;
            $display("FAIL %s resp: got busy/r0v/r1v/val/err=%b expected %b", name,
                     {busy, resp0_valid, resp1_valid, resp_val, resp_err},
                     {1'b1, exp_r0, exp_r1, exp_val, exp_err});
        end
        @(negedge clk);                  // T+3 (IDLE), the result is held
        checks++;
        if ({busy, resp0_valid, resp1_valid, resp_val, resp_err} !==
            {3'b000, exp_val, exp_err}) begin
            errors++;
            $display("FAIL %s after: got busy/r0v/r1v/val/err=%b expected %b", name,
                     {busy, resp0_valid, resp1_valid, resp_val, resp_err},
                     {3'b000, exp_val, exp_err});
        end
    endtask

    task automatic test_reset;
        rst = 1'b1;
        drive(0, '0, '0, 3'b000, 1'b0);
        drive(1, '0, '0, 3'b000, 1'b0);
        repeat (2) @(negedge clk);
        checks++;
        if ({busy, resp0_valid, resp1_valid, resp_val, resp_err, req0_ready, req1_ready} !== 7'b0) begin
            errors++;
            $display("FAIL reset_outputs: got %b expected 0000000",
                     {busy, resp0_valid, resp1_valid, resp_val, resp_err, req0_ready, req1_ready});
        end
        // The first tie goes to requester 0 (last_grant resets to 1).
        req0_valid = 1'b1;
        req1_valid = 1'b1;
        #1;
        checks++;
        if ({req0_ready, req1_ready} !== 2'b10) begin
            errors++;
            $display("FAIL reset_first_tie: got r0=%b r1=%b expected r0=1 r1=0",
                     req0_ready, req1_ready);
        end
        req0_valid = 1'b0;
        req1_valid = 1'b0;
        @(negedge clk);
        rst = 1'b0;
    endtask

    task automatic test_req0_basic;
        single_txn("req0_5_lt_7", 0, 32'd5, 32'd7, 3'b010, 1'b1, 1'b0);
    endtask

    task automatic test_back_to_back;
        @(negedge clk);                  // T
        drive(1, 32'd9, 32'd9, 3'b011, 1'b1);
        #1;
        checks++;
        if ({req0_ready, req1_ready} !== 2'b01) begin
            errors++;
            $display("FAIL b2b ready@T: got r0=%b r1=%b expected r0=0 r1=1", req0_ready, req1_ready);
        end
        @(negedge clk);                  // T+1: valid held, no ready
        drive(1, 32'd9, 32'd9, 3'b001, 1'b1);
        #1;
        checks++;
        if (req1_ready !== 1'b0) begin
            errors++;
            $display("FAIL b2b ready@T+1: got %b expected 0", req1_ready);
        end
        @(negedge clk);                  // T+2
        checks++;
        if ({resp1_valid, resp0_valid, resp_val, req1_ready} !== 4'b1010) begin
            errors++;
            $display("FAIL b2b le_resp: got r1v/r0v/val/rdy1=%b expected 1010",
                     {resp1_valid, resp0_valid, resp_val, req1_ready});
        end
        #1;
        @(negedge clk);                  // T+3: second handshake
        #1;
        checks++;
        if (req1_ready !== 1'b1) begin
            errors++;
            $display("FAIL b2b ready@T+3: got %b expected 1", req1_ready);
        end
        @(negedge clk);                  // T+4
        drive(1, 32'd9, 32'd9, 3'b001, 1'b0);
        @(negedge clk);                  // T+5
        checks++;
        if ({resp1_valid, resp_val, resp_err} !== 3'b100) begin
            errors++;
            $display("FAIL b2b ne_resp: got r1v/val/err=%b expected 100",
                     {resp1_valid, resp_val, resp_err});
        end
        @(negedge clk);
    endtask

    task automatic test_both_valid;
        logic exp_id;
        @(negedge clk);
        drive(0, 32'd1, 32'd2, 3'b010, 1'b1);   // requester 0 result 1
        drive(1, 32'd3, 32'd2, 3'b010, 1'b1);   // requester 1 result 0
        for (int i = 0; i < 4; i++) begin
`ifdef CMP_ARB_FIXED_PRIO_EN
            exp_id = 1'b0;
`else
            exp_id = (i % 2 == 1);
`endif
            #1;
            checks++;
            if ({req0_ready, req1_ready} !== {~exp_id, exp_id}) begin
                errors++;
                $display("FAIL both grant%0d: got r0=%b r1=%b expected r0=%b r1=%b",
                         i, req0_ready, req1_ready, ~exp_id, exp_id);
            end
            @(negedge clk);
            @(negedge clk);
            checks++;
            if ({resp0_valid, resp1_valid, resp_val} !== {~exp_id, exp_id, ~exp_id}) begin
                errors++;
                $display("FAIL both resp%0d: got r0v/r1v/val=%b expected %b",
                         i, {resp0_valid, resp1_valid, resp_val}, {~exp_id, exp_id, ~exp_id});
            end
            @(negedge clk);
        end
        drive(0, '0, '0, 3'b000, 1'b0);
        drive(1, '0, '0, 3'b000, 1'b0);
    endtask

    task automatic test_illegal;
        single_txn("illegal_111", 0, 32'd1, 32'd2, 3'b111, 1'b0, 1'b1);
        single_txn("illegal_110", 1, 32'd5, 32'd5, 3'b110, 1'b0, 1'b1);
        single_txn("resume_lt", 1, 32'd1, 32'd2, 3'b010, 1'b1, 1'b0);
    endtask

    task automatic test_ops;
        single_txn("eq_true", 0, 32'd42, 32'd42, 3'b000, 1'b1, 1'b0);
        single_txn("gt_true", 1, 32'd9, 32'd4, 3'b100, 1'b1, 1'b0);
        single_txn("gt_equal", 0, 32'd4, 32'd4, 3'b100, 1'b0, 1'b0);
        single_txn("ge_false", 1, 32'd4, 32'd9, 3'b101, 1'b0, 1'b0);
    endtask

    task automatic test_reset_in_exec;
        @(negedge clk);                  // T
        drive(0, 32'd3, 32'd3, 3'b000, 1'b1);
        #1;
        checks++;
        if (req0_ready !== 1'b1) begin
            errors++;
            $display("FAIL rst_exec ready@T: got %b expected 1", req0_ready);
        end
        @(negedge clk);                  // T+1 (EXEC): reset asserted
        drive(0, 32'd3, 32'd3, 3'b000, 1'b0);
        rst = 1'b1;
        @(negedge clk);                  // T+2: the response is discarded
        checks++;
        if ({resp0_valid, resp1_valid, busy, resp_val, resp_err} !== 5'b0) begin
            errors++;
            $display("FAIL rst_exec discard: got r0v/r1v/busy/val/err=%b expected 00000",
                     {resp0_valid, resp1_valid, busy, resp_val, resp_err});
        end
        rst = 1'b0;
        @(negedge clk);
        checks++;
        if ({resp0_valid, busy} !== 2'b00) begin
            errors++;
            $display("FAIL rst_exec quiet: got r0v/busy=%b expected 00", {resp0_valid, busy});
        end
        single_txn("rst_exec_fresh", 0, 32'd3, 32'd3, 3'b000, 1'b1, 1'b0);
    endtask

    task automatic test_no_overflow;
        single_txn("min_lt_one", 0, 32'h8000_0000, 32'd1, 3'b010, 1'b0, 1'b0);
        single_txn("max_lt_min", 1, 32'h7fff_ffff, 32'h8000_0000, 3'b010, 1'b1, 1'b0);
    endtask

    initial begin
        test_reset();
        test_req0_basic();
        test_back_to_back();
        test_both_valid();
        test_illegal();
        test_ops();
        test_reset_in_exec();
        test_no_overflow();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
